// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit_serializer slice: FSM state encodings and default word width.
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } state_e;

endpackage

// File: rtl/ser_shift_reg.sv
// WIDTH-bit load/shift register; vacated positions fill with IDLE_BIT so the serial
// output falls back to the idle level by itself once a word has been fully shifted out.
module ser_shift_reg #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Next contents: load wins over shift; shifting pulls the idle level in behind the data.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], IDLE_BIT};
      end else begin
        sr_d = {IDLE_BIT, sr_q[WIDTH-1:1]};
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register state; reset parks the output at the idle level immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= {WIDTH{IDLE_BIT}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial source: one holding register in front of a shift register gives
// gapless back-to-back streaming on X, with an underrun pulse when the stream runs dry.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             X,
  output logic             x_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_valid_q, x_valid_d;
  logic             underrun_q, underrun_d;
  logic             ready_q, ready_d;
  logic             accept_s, sr_load_s, sr_shift_s;

  assign accept_s = load_valid & ready_q;

  // Next-state logic: accept and hold->shifter transfer are mutually exclusive since ready = !hold_full.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    x_valid_d   = x_valid_q;
    underrun_d  = 1'b0;
    sr_load_s   = 1'b0;
    sr_shift_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          sr_load_s   = 1'b1;
          hold_full_d = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          x_valid_d   = 1'b1;
          state_d     = ST_SHIFT;
        end else begin
          x_valid_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          if (hold_full_q) begin
            sr_load_s   = 1'b1;
            hold_full_d = 1'b0;
            cnt_d       = {CNT_W{1'b0}};
            x_valid_d   = 1'b1;
          end else begin
            sr_shift_s  = 1'b1;
            x_valid_d   = 1'b0;
            underrun_d  = 1'b1;
            state_d     = ST_IDLE;
          end
        end else begin
          sr_shift_s = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        x_valid_d = 1'b0;
      end
    endcase
    if (accept_s) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end
    ready_d = ~hold_full_d;
  end

  // Control and holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= {WIDTH{1'b0}};
      hold_full_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      x_valid_q   <= 1'b0;
      underrun_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      x_valid_q   <= x_valid_d;
      underrun_q  <= underrun_d;
      ready_q     <= ready_d;
    end
  end

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDLE_BIT  (IDLE_BIT)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sr_load_s),
    .shift_i (sr_shift_s),
    .data_i  (hold_q),
    .ser_o   (X)
  );

  assign load_ready = ready_q;
  assign x_valid    = x_valid_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q == ST_SHIFT) | hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: an MSB-first/idle-0 and an LSB-first/idle-1 instance share stimulus
// and are compared every cycle against a word/bit-count reference model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         ready_m, x_m, xv_m, busy_m, und_m;
  logic         ready_l, x_l, xv_l, busy_l, und_l;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: word currently on the wire, bits still to send, and the hold slot.
  logic [W-1:0] cur_w, hold_w;
  logic         hold_v, m_out, m_under;
  int           bits_left;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .X(x_m), .x_valid(xv_m), .busy(busy_m), .underrun(und_m));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .X(x_l), .x_valid(xv_l), .busy(busy_l), .underrun(und_l));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    bits_left = 0;
    hold_v    = 1'b0;
    m_out     = 1'b0;
    m_under   = 1'b0;
  endtask

  task automatic check_all();
    logic e_xm, e_xl;
    e_xm = (bits_left > 0) ? cur_w[bits_left-1] : 1'b0;
    e_xl = (bits_left > 0) ? cur_w[W-bits_left] : 1'b1;
    chk("ready_m", ready_m, m_out && !hold_v);
    chk("x_m",     x_m,     e_xm);
    chk("xv_m",    xv_m,    bits_left > 0);
    chk("busy_m",  busy_m,  (bits_left > 0) || hold_v);
    chk("und_m",   und_m,   m_under);
    chk("ready_l", ready_l, m_out && !hold_v);
    chk("x_l",     x_l,     e_xl);
    chk("xv_l",    xv_l,    bits_left > 0);
    chk("busy_l",  busy_l,  (bits_left > 0) || hold_v);
    chk("und_l",   und_l,   m_under);
  endtask

  // One clock: decide acceptance before the edge, advance the model, check after the edge.
  task automatic step(output bit acc);
    logic [W-1:0] d;
    bit           was_last;
    acc = load_valid && m_out && !hold_v;
    d   = data_in;
    @(posedge clk);
    if (reset) begin
      model_clear();
      acc = 1'b0;
    end else begin
      was_last = (bits_left == 1);
      if (bits_left > 0) bits_left--;
      if (bits_left == 0 && hold_v) begin
        cur_w     = hold_w;
        bits_left = W;
        hold_v    = 1'b0;
      end
      m_under = was_last && (bits_left == 0);
      if (acc) begin
        hold_w = d;
        hold_v = 1'b1;
      end
      m_out = 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc;
    int n;
    load_valid = 1'b1;
    data_in    = w;
    acc        = 1'b0;
    n          = 0;
    while (!acc && n < 40) begin
      step(acc);
      n++;
    end
    chk("accept_timeout", acc, 1'b1);
    load_valid = 1'b0;
    data_in    = W'($urandom);
  endtask

  // Collects the next W bits of each instance, first bit into the MSB position.
  task automatic capture(output logic [W-1:0] cm, output logic [W-1:0] cl);
    bit a;
    cm = '0;
    cl = '0;
    for (int i = 0; i < W; i++) begin
      step(a);
      cm = {cm[W-2:0], x_m};
      cl = {cl[W-2:0], x_l};
    end
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    model_clear();
    #1 check_all();
    idle(2);
    #2 reset = 1'b0;
    #1 check_all();
    idle(1);
  endtask

  initial begin
    logic [W-1:0] cm, cl;
    int           nund;
    bit           a;

    reset      = 1'b1;
    load_valid = 1'b0;
    data_in    = '0;
    model_clear();
    #1 check_all();
    idle(2);
    #2 reset = 1'b0;
    #1 check_all();
    idle(1);
    chk("ready_after_release", ready_m, 1'b1);

    // Single word 8'hC8, then underrun
    send(8'hC8);
    capture(cm, cl);
    chk("t2_msb_bits", cm, 8'hC8);
    chk("t2_lsb_bits", cl, 8'h13);
    step(a);
    chk("t2_underrun", und_m, 1'b1);
    idle(3);

    // Back-to-back 8'hC8, 8'h8C: exactly one underrun
    send(8'hC8);
    send(8'h8C);
    nund = 0;
    for (int i = 0; i < 20; i++) begin
      step(a);
      if (und_m) nund++;
    end
    chk("t3_single_underrun", nund, 1);

    // LSB-first view of 8'h13
    send(8'h13);
    capture(cm, cl);
    chk("t6_msb_bits", cm, 8'h13);
    chk("t6_lsb_bits", cl, 8'hC8);
    idle(3);

    // Hold full, valid high with changing data: ignored until ready returns
    send(8'hA1);
    send(8'hB2);
    load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = W'($urandom);
      step(a);
    end
    chk("t4_ready_low", ready_m, 1'b0);
    send(8'h3C);
    idle(30);

    // Reset mid-word with a word held, then a fresh word
    send(8'hFF);
    send(8'hAA);
    step(a);
    mid_reset();
    chk("t5_busy_after_reset", busy_m, 1'b0);
    send(8'h0F);
    capture(cm, cl);
    chk("t5_msb_bits", cm, 8'h0F);
    chk("t5_lsb_bits", cl, 8'hF0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      data_in    = W'($urandom);
      step(a);
      if (i == 200) mid_reset();
    end
    load_valid = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
